regfile_wb_ctrl: RTL

Write-back controller for the 32 x 32-bit register file, which has a single write port. It arbitrates that port round-robin between the ALU write-back stream and the load-unit write-back stream, registers the winning write, and drives the register file's `we` / `reg_to_write_addr` / `reg_to_write_data`. It also keeps a scoreboard of registers with loads in flight and flags read-after-write hazards to the issue stage.

---
 rtl/regfile_wb_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU/load writes onto the single
// register-file write port, plus a load-in-flight scoreboard. Optional WB_CONFLICT_CNT_EN.
module regfile_wb_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        issue_ld_valid,
  input  logic [4:0]  issue_ld_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard,
  output logic        sb_err,
  output logic        we,
  output logic [4:0]  reg_to_write_addr,
  output logic [31:0] reg_to_write_data,
  output logic [15:0] conflict_cnt
);

  localparam logic WIN_ALU = 1'b0;
  localparam logic WIN_LD  = 1'b1;

  logic        last_winner_q, last_winner_d;
  logic        we_q, we_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_is_ld_q, wb_is_ld_d;
  logic [31:0] busy_q, busy_d;
  logic        sb_err_q, sb_err_d;
  logic        conflict, grant_alu, grant_ld;
  logic [31:0] set_mask, clr_mask;

  always_comb begin
    conflict  = alu_valid && ld_valid;
    // On a conflict the side that did not win last time gets the port.
    grant_alu = alu_valid && (!ld_valid || (last_winner_q == WIN_LD));
    grant_ld  = ld_valid && !grant_alu;

    last_winner_d = last_winner_q;
    if (conflict) last_winner_d = grant_ld ? WIN_LD : WIN_ALU;

    we_d       = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_is_ld_d = wb_is_ld_q;
    if (grant_ld) begin
      we_d       = (ld_addr != 5'd0);
      wb_addr_d  = ld_addr;
      wb_data_d  = ld_data;
      wb_is_ld_d = 1'b1;
    end else if (grant_alu) begin
      we_d       = (alu_addr != 5'd0);
      wb_addr_d  = alu_addr;
      wb_data_d  = alu_data;
      wb_is_ld_d = 1'b0;
    end

    // Set is OR'd after the clear so a same-edge issue to the retiring register wins.
    set_mask = (issue_ld_valid && (issue_ld_addr != 5'd0)) ? (32'd1 << issue_ld_addr) : 32'd0;
    clr_mask = (we_q && wb_is_ld_q) ? (32'd1 << wb_addr_q) : 32'd0;
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    sb_err_d = sb_err_q | (issue_ld_valid && busy_q[issue_ld_addr]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_winner_q <= WIN_ALU;
      we_q          <= 1'b0;
      wb_addr_q     <= 5'd0;
      wb_data_q     <= 32'd0;
      wb_is_ld_q    <= 1'b0;
      busy_q        <= 32'd0;
      sb_err_q      <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      we_q          <= we_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_is_ld_q    <= wb_is_ld_d;
      busy_q        <= busy_d;
      sb_err_q      <= sb_err_d;
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 16'd0;
`endif

  assign alu_ready         = grant_alu && !reset;
  assign ld_ready          = grant_ld && !reset;
  assign hazard            = busy_q[rs1_addr] | busy_q[rs2_addr];
  assign sb_err            = sb_err_q;
  assign we                = we_q;
  assign reg_to_write_addr = wb_addr_q;
  assign reg_to_write_data = wb_data_q;

endmodule
